// File: rtl/vend_pkg.sv
// Shared vending definitions: coin codes consumed by the vending FSM and
// the acceptor state encoding. Used by coin_acceptor (optional feature
// macro: COIN_COUNTER_EN).
package vend_pkg;

  // Coin codes on the acceptor -> vending FSM interface
  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_ONE  = 2'b01;
  localparam logic [1:0] COIN_TWO  = 2'b10;

  // Acceptor state encoding
  typedef enum logic [1:0] {
    IDLE         = 2'b00,
    DEBOUNCE     = 2'b01,
    EMIT         = 2'b10,
    WAIT_RELEASE = 2'b11
  } acc_state_t;

  // Monetary value of a coin code in units (0 for anything not a coin)
  function automatic logic [1:0] coin_units(input logic [1:0] code);
    logic [1:0] units;
    units = 2'd0;
    if (code == COIN_ONE) units = 2'd1;
    if (code == COIN_TWO) units = 2'd2;
    return units;
  endfunction

endpackage

// File: rtl/coin_acceptor_sync2.sv
// Two-flop synchroniser for one asynchronous sensor line, async reset to 0.
module sync2 (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_async,
  output logic o_sync
);

  logic r_meta;
  logic r_sync;

  // Shift the raw level through two flops to settle metastability
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end

  assign o_sync = r_sync;

endmodule

// File: rtl/coin_acceptor.sv
// Coin acceptor front end: synchronises and debounces the 1-unit and 2-unit
// sensors and emits one clean coin code (or a reject pulse) per insertion.
// Optional running total of accepted units: define COIN_COUNTER_EN.
module coin_acceptor
  import vend_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       coin1_raw,
  input  logic       coin2_raw,
  input  logic       enable,
`ifdef COIN_COUNTER_EN
  input  logic       clr_count,
  output logic [7:0] total_units,
`endif
  output logic [1:0] coin,
  output logic       reject
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic w_s1;
  logic w_s2;

  acc_state_t       r_state;
  acc_state_t       w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic [1:0]       r_code;
  logic [1:0]       w_code_next;
  logic [1:0]       r_coin;
  logic [1:0]       w_coin_next;
  logic             r_reject;
  logic             w_reject_next;
  logic             w_latched_high;
  logic             w_other_high;

  sync2 u_sync_coin1 (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_async (coin1_raw),
    .o_sync  (w_s1)
  );

  sync2 u_sync_coin2 (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_async (coin2_raw),
    .o_sync  (w_s2)
  );

  // Which synced sensor belongs to the coin currently being debounced
  assign w_latched_high = (r_code == COIN_ONE) ? w_s1 : w_s2;
  assign w_other_high   = (r_code == COIN_ONE) ? w_s2 : w_s1;

  // State, counter, latched code and registered output pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_code   <= COIN_NONE;
      r_coin   <= COIN_NONE;
      r_reject <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_cnt    <= w_cnt_next;
      r_code   <= w_code_next;
      r_coin   <= w_coin_next;
      r_reject <= w_reject_next;
    end
  end

  // Next-state and debounce counter logic
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_code_next  = r_code;
    case (r_state)
      IDLE: begin
        w_cnt_next = '0;
        if (w_s1 && w_s2) begin
          w_state_next = WAIT_RELEASE;
        end else if (w_s1 || w_s2) begin
          w_code_next  = w_s1 ? COIN_ONE : COIN_TWO;
          w_state_next = DEBOUNCE;
        end
      end
      DEBOUNCE: begin
        if (!w_latched_high) begin
          w_state_next = IDLE;
        end else if (w_other_high) begin
          w_cnt_next   = '0;
          w_state_next = WAIT_RELEASE;
        end else if (r_cnt == CNT_LAST) begin
          w_state_next = EMIT;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      EMIT: begin
        w_cnt_next   = '0;
        w_state_next = WAIT_RELEASE;
      end
      WAIT_RELEASE: begin
        if (w_s1 || w_s2) begin
          w_cnt_next = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_cnt_next   = '0;
          w_state_next = IDLE;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Output decode: pulses are computed on the transition so that the
  // registered outputs line up with the EMIT cycle (enable is sampled on
  // the edge that enters EMIT) and with the first WAIT_RELEASE cycle.
  always_comb begin
    w_coin_next   = COIN_NONE;
    w_reject_next = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_s1 && w_s2) w_reject_next = 1'b1;
      end
      DEBOUNCE: begin
        if (w_latched_high && w_other_high) begin
          w_reject_next = 1'b1;
        end else if (w_latched_high && (r_cnt == CNT_LAST)) begin
          if (enable) w_coin_next = r_code;
          else        w_reject_next = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign coin   = r_coin;
  assign reject = r_reject;

`ifdef COIN_COUNTER_EN
  logic [7:0] r_total;
  logic [8:0] w_sum;

  assign w_sum = {1'b0, r_total} + {7'd0, coin_units(r_coin)};

  // Running total of accepted units, saturating, clear wins over add
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_total <= 8'd0;
    end else if (clr_count) begin
      r_total <= 8'd0;
    end else if (r_coin != COIN_NONE) begin
      r_total <= w_sum[8] ? 8'hFF : w_sum[7:0];
    end
  end

  assign total_units = r_total;
`endif

endmodule

// File: tb/tb_coin_acceptor.sv
// Self-checking bench for coin_acceptor (DEBOUNCE_CYCLES=4). Expected coin /
// reject events with their arrival cycle are queued when stimulus is driven
// and consumed as the DUT pulses its outputs.
module tb_coin_acceptor;
  import vend_pkg::*;

  localparam int DEB = 4;
  // Raw edge driven at a negedge in cycle d shows on the outputs in cycle d+3+DEB
  localparam int LAT = 3 + DEB;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       coin1_raw = 1'b0;
  logic       coin2_raw = 1'b0;
  logic       enable = 1'b1;
  logic [1:0] coin;
  logic       reject;
`ifdef COIN_COUNTER_EN
  logic       clr_count = 1'b0;
  logic [7:0] total_units;
`endif

  typedef struct {
    logic [1:0] coin;
    logic       rej;
    int         cyc;
  } ev_t;

  ev_t exp_q[$];
  int  cyc = 0;
  int  checks = 0;
  int  failures = 0;

  coin_acceptor #(.DEBOUNCE_CYCLES(DEB), .CNT_W(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .coin1_raw   (coin1_raw),
    .coin2_raw   (coin2_raw),
    .enable      (enable),
`ifdef COIN_COUNTER_EN
    .clr_count   (clr_count),
    .total_units (total_units),
`endif
    .coin        (coin),
    .reject      (reject)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic ev_t mk(input logic [1:0] c, input logic r, input int t);
    ev_t e;
    e.coin = c;
    e.rej  = r;
    e.cyc  = t;
    return e;
  endfunction

  // Scoreboard consumer: advance n cycles, matching every output pulse
  task automatic score_cycles(input int n);
    ev_t e;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (coin !== COIN_NONE || reject !== 1'b0) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_pulse cyc=%0d coin=%b reject=%b required none", cyc, coin, reject);
        end else begin
          e = exp_q.pop_front();
          if (coin !== e.coin || reject !== e.rej || cyc !== e.cyc) begin
            failures++;
            $display("FAIL pulse got coin=%b reject=%b cyc=%0d required coin=%b reject=%b cyc=%0d",
                     coin, reject, cyc, e.coin, e.rej, e.cyc);
          end else begin
            $display("event coin=%b reject=%b cyc=%0d ok", coin, reject, cyc);
          end
        end
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (coin !== COIN_NONE || reject !== 1'b0 || dut.r_state !== IDLE || dut.r_cnt !== 8'd0) begin
      failures++;
      $display("FAIL reset_state coin=%b reject=%b state=%0d cnt=%0d required 00 0 IDLE 0",
               coin, reject, dut.r_state, dut.r_cnt);
    end
    rst_n = 1'b1;
    score_cycles(4);
    $display("test_reset done");
  endtask

  task automatic test_single_coin1();
    int d;
    d = cyc;
    exp_q.push_back(mk(COIN_ONE, 1'b0, d + LAT));
    coin1_raw = 1'b1;
    score_cycles(20);
    coin1_raw = 1'b0;
    score_cycles(5);
    checks++;
    if (dut.r_state === IDLE) begin
      failures++;
      $display("FAIL release_early state=%0d required not IDLE", dut.r_state);
    end
    score_cycles(1);
    checks++;
    if (dut.r_state !== IDLE) begin
      failures++;
      $display("FAIL release_idle state=%0d required IDLE", dut.r_state);
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL single_coin1_missing pending=%0d required 0", exp_q.size());
      exp_q.delete();
    end
    $display("test_single_coin1 done");
  endtask

  task automatic test_glitch();
    coin2_raw = 1'b1;
    score_cycles(2);
    coin2_raw = 1'b0;
    score_cycles(10);
    checks++;
    if (dut.r_state !== IDLE) begin
      failures++;
      $display("FAIL glitch_idle state=%0d required IDLE", dut.r_state);
    end
    $display("test_glitch done");
  endtask

  task automatic test_both();
    int d;
    d = cyc;
    exp_q.push_back(mk(COIN_NONE, 1'b1, d + 3));
    coin1_raw = 1'b1;
    coin2_raw = 1'b1;
    score_cycles(10);
    coin1_raw = 1'b0;
    score_cycles(12);
    checks++;
    if (dut.r_state !== WAIT_RELEASE) begin
      failures++;
      $display("FAIL both_hold state=%0d required WAIT_RELEASE", dut.r_state);
    end
    coin2_raw = 1'b0;
    score_cycles(8);
    checks++;
    if (dut.r_state !== IDLE || exp_q.size() != 0) begin
      failures++;
      $display("FAIL both_end state=%0d pending=%0d required IDLE 0", dut.r_state, exp_q.size());
      exp_q.delete();
    end
    $display("test_both done");
  endtask

  task automatic test_enable();
    int d;
    enable = 1'b0;
    d = cyc;
    exp_q.push_back(mk(COIN_NONE, 1'b1, d + LAT));
    coin2_raw = 1'b1;
    score_cycles(20);
    coin2_raw = 1'b0;
    score_cycles(8);
    enable = 1'b1;
    d = cyc;
    exp_q.push_back(mk(COIN_TWO, 1'b0, d + LAT));
    coin2_raw = 1'b1;
    score_cycles(20);
    coin2_raw = 1'b0;
    score_cycles(8);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL enable_missing pending=%0d required 0", exp_q.size());
      exp_q.delete();
    end
    $display("test_enable done");
  endtask

  task automatic test_abort_other();
    int d;
    d = cyc;
    exp_q.push_back(mk(COIN_NONE, 1'b1, d + 5));
    coin1_raw = 1'b1;
    score_cycles(2);
    coin2_raw = 1'b1;
    score_cycles(12);
    coin1_raw = 1'b0;
    coin2_raw = 1'b0;
    score_cycles(8);
    checks++;
    if (exp_q.size() != 0 || dut.r_state !== IDLE) begin
      failures++;
      $display("FAIL abort_other pending=%0d state=%0d required 0 IDLE", exp_q.size(), dut.r_state);
      exp_q.delete();
    end
    $display("test_abort_other done");
  endtask

  task automatic test_reset_mid();
    int r;
    coin1_raw = 1'b1;
    score_cycles(4);
    checks++;
    if (dut.r_state !== DEBOUNCE) begin
      failures++;
      $display("FAIL mid_pre state=%0d required DEBOUNCE", dut.r_state);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (coin !== COIN_NONE || reject !== 1'b0 || dut.r_state !== IDLE) begin
      failures++;
      $display("FAIL mid_reset coin=%b reject=%b state=%0d required 00 0 IDLE", coin, reject, dut.r_state);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    r = cyc;
    exp_q.push_back(mk(COIN_ONE, 1'b0, r + LAT));
    score_cycles(20);
    coin1_raw = 1'b0;
    score_cycles(10);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL mid_missing pending=%0d required 0", exp_q.size());
      exp_q.delete();
    end
    $display("test_reset_mid done");
  endtask

`ifdef COIN_COUNTER_EN
  task automatic test_counter();
    int d;
    int model;
    clr_count = 1'b1;
    score_cycles(1);
    clr_count = 1'b0;
    checks++;
    if (total_units !== 8'd0) begin
      failures++;
      $display("FAIL count_clear got=%0d required 0", total_units);
    end
    model = 0;
    for (int k = 0; k < 130; k++) begin
      d = cyc;
      exp_q.push_back(mk(COIN_TWO, 1'b0, d + LAT));
      coin2_raw = 1'b1;
      score_cycles(10);
      coin2_raw = 1'b0;
      score_cycles(8);
      model = (model + 2 > 255) ? 255 : model + 2;
    end
    checks++;
    if (total_units !== model[7:0] || exp_q.size() != 0) begin
      failures++;
      $display("FAIL count_sat got=%0d pending=%0d required %0d 0", total_units, exp_q.size(), model);
      exp_q.delete();
    end
    d = cyc;
    exp_q.push_back(mk(COIN_TWO, 1'b0, d + LAT));
    coin2_raw = 1'b1;
    score_cycles(LAT);
    clr_count = 1'b1;
    score_cycles(1);
    clr_count = 1'b0;
    checks++;
    if (total_units !== 8'd0) begin
      failures++;
      $display("FAIL count_clr_priority got=%0d required 0", total_units);
    end
    score_cycles(5);
    coin2_raw = 1'b0;
    score_cycles(8);
    $display("test_counter done total=%0d", total_units);
  endtask
`endif

  initial begin
    test_reset();
    test_single_coin1();
    test_glitch();
    test_both();
    test_enable();
    test_abort_other();
    test_reset_mid();
`ifdef COIN_COUNTER_EN
    test_counter();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
